// File: rtl/sonuc_bcd_if.sv
// ----------------------------------------------------------------------------
// sonuc_bcd_if
// Bus bundle between a calculator core / display controller (master) and the
// binary-to-BCD converter (slave).
//
// Signals
//   sonuc      [63:0] binary result from the calculator core
//   gecerli_in        core result-valid flag
//   tasma_in          core overflow flag
//   basla             start request, honoured only while hazir=1
//   bcd        [79:0] 20 packed BCD digits, digit 0 in [3:0]
//   isaret            sign of the displayed value (1 = negative)
//   hazir             converter idle, ready to accept basla
//   tamam             one-cycle completion pulse
//   gecerli           bcd holds a valid conversion
//   tasma             registered copy of the captured tasma_in
// ----------------------------------------------------------------------------
interface sonuc_bcd_if;
  logic [63:0] sonuc;
  logic        gecerli_in;
  logic        tasma_in;
  logic        basla;
  logic [79:0] bcd;
  logic        isaret;
  logic        hazir;
  logic        tamam;
  logic        gecerli;
  logic        tasma;

  modport master (
    output sonuc, gecerli_in, tasma_in, basla,
    input  bcd, isaret, hazir, tamam, gecerli, tasma
  );

  modport slave (
    input  sonuc, gecerli_in, tasma_in, basla,
    output bcd, isaret, hazir, tamam, gecerli, tasma
  );
endinterface

// File: rtl/sonuc_bcd.sv
// ----------------------------------------------------------------------------
// sonuc_bcd
// Converts a 64-bit calculator result into 20 packed BCD digits using the
// shift-and-add-3 (double dabble) algorithm, one operand bit per clock.
//
// Ports
//   clk  : single clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : sonuc_bcd_if.slave (operand/flags/start in, digits/status out)
//
// Timing (k = edge on which basla is accepted while hazir=1)
//   conversion path : iterations on edges k+1..k+64, tamam high after k+64,
//                     hazir high again after k+65
//   error path      : (gecerli_in=0 or tasma_in=1 at capture) tamam high
//                     after k+1, hazir high again after k+2
//
// Configuration
//   ISARETLI_SONUC_EN defined   : sonuc is two's complement; negative values
//                                 are converted as magnitude and isaret=1.
//   ISARETLI_SONUC_EN undefined : sonuc is unsigned, isaret is tied to 0.
//   Latency and handshake are identical in both builds.
// ----------------------------------------------------------------------------
module sonuc_bcd (
  input  logic       clk,
  input  logic       rst,
  sonuc_bcd_if.slave bus
);

  typedef enum logic [1:0] {
    BOSTA    = 2'd0,
    DONUSTUR = 2'd1,
    BITTI    = 2'd2
  } durum_t;

  // Add 3 to every digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [79:0] basamak_duzelt(input logic [79:0] d);
    logic [79:0] r;
    r = d;
    for (int i = 0; i < 20; i++) begin
      if (d[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = d[4*i +: 4];
      end
    end
    return r;
  endfunction

  durum_t      durum;
  durum_t      durum_next;

  // Working registers of the conversion
  logic [79:0] basamak;      // digit accumulator
  logic [63:0] islenen;      // operand, shifted out MSB first
  logic [6:0]  sayac;        // completed iteration count
  logic        hata;         // captured gecerli_in=0 or tasma_in=1
  logic        tasma_yakala; // captured tasma_in

  // Held output registers
  logic [79:0] bcd_q;
  logic        hazir_q;
  logic        tamam_q;
  logic        gecerli_q;
  logic        tasma_q;

  // Combinational step of one iteration
  logic [79:0] basamak_duz;
  logic [79:0] basamak_kay;
  logic        son_adim;
  logic [63:0] yukle;

`ifdef ISARETLI_SONUC_EN
  logic        negatif;
  logic        isaret_q;
`endif

  // Operand to load at capture: magnitude in the signed build, raw otherwise.
`ifdef ISARETLI_SONUC_EN
  always_comb begin
    if (bus.sonuc[63]) begin
      yukle = 64'd0 - bus.sonuc;
    end else begin
      yukle = bus.sonuc;
    end
  end
`else
  assign yukle = bus.sonuc;
`endif

  // One double-dabble step: adjust digits, then shift the operand MSB in.
  always_comb begin
    basamak_duz = basamak_duzelt(basamak);
    basamak_kay = {basamak_duz[78:0], islenen[63]};
    son_adim    = (sayac == 7'd63);
  end

  // Next-state logic. The captured flags are evaluated in the first
  // DONUSTUR cycle, so an error result completes on edge k+1 with the same
  // BITTI/BOSTA tail as a normal conversion.
  always_comb begin
    durum_next = durum;
    case (durum)
      BOSTA: begin
        if (bus.basla) begin
          durum_next = DONUSTUR;
        end else begin
          durum_next = BOSTA;
        end
      end
      DONUSTUR: begin
        if (hata || son_adim) begin
          durum_next = BITTI;
        end else begin
          durum_next = DONUSTUR;
        end
      end
      BITTI: begin
        durum_next = BOSTA;
      end
      default: begin
        durum_next = BOSTA;
      end
    endcase
  end

  // State register, conversion datapath and held outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      durum        <= BOSTA;
      basamak      <= 80'd0;
      islenen      <= 64'd0;
      sayac        <= 7'd0;
      hata         <= 1'b0;
      tasma_yakala <= 1'b0;
      bcd_q        <= 80'd0;
      hazir_q      <= 1'b1;
      tamam_q      <= 1'b0;
      gecerli_q    <= 1'b0;
      tasma_q      <= 1'b0;
`ifdef ISARETLI_SONUC_EN
      negatif      <= 1'b0;
      isaret_q     <= 1'b0;
`endif
    end else begin
      durum   <= durum_next;
      hazir_q <= (durum_next == BOSTA);
      tamam_q <= 1'b0;
      case (durum)
        BOSTA: begin
          if (bus.basla) begin
            islenen      <= yukle;
            hata         <= (~bus.gecerli_in) | bus.tasma_in;
            tasma_yakala <= bus.tasma_in;
            basamak      <= 80'd0;
            sayac        <= 7'd0;
`ifdef ISARETLI_SONUC_EN
            negatif      <= bus.sonuc[63];
`endif
          end
        end
        DONUSTUR: begin
          if (hata) begin
            bcd_q     <= 80'd0;
            gecerli_q <= 1'b0;
            tasma_q   <= tasma_yakala;
            tamam_q   <= 1'b1;
`ifdef ISARETLI_SONUC_EN
            isaret_q  <= 1'b0;
`endif
          end else begin
            basamak <= basamak_kay;
            islenen <= {islenen[62:0], 1'b0};
            sayac   <= sayac + 7'd1;
            if (son_adim) begin
              bcd_q     <= basamak_kay;
              gecerli_q <= 1'b1;
              tasma_q   <= 1'b0;
              tamam_q   <= 1'b1;
`ifdef ISARETLI_SONUC_EN
              isaret_q  <= negatif;
`endif
            end
          end
        end
        BITTI: begin
          sayac <= 7'd0;
        end
        default: begin
          sayac <= 7'd0;
        end
      endcase
    end
  end

  assign bus.bcd     = bcd_q;
  assign bus.hazir   = hazir_q;
  assign bus.tamam   = tamam_q;
  assign bus.gecerli = gecerli_q;
  assign bus.tasma   = tasma_q;
`ifdef ISARETLI_SONUC_EN
  assign bus.isaret  = isaret_q;
`else
  assign bus.isaret  = 1'b0;
`endif

endmodule

// File: tb/tb_sonuc_bcd.sv
// Scoreboard bench for sonuc_bcd: stimulus pushes expected results computed
// by decimal arithmetic; a monitor pops and compares on every tamam pulse.
module tb_sonuc_bcd;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sonuc_bcd_if bus ();

  sonuc_bcd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [79:0] bcd;
    logic        isaret;
    logic        gecerli;
    logic        tasma;
    int          cyc;
  } beklenen_t;

  beklenen_t   sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic        prev_tamam = 1'b0;
  logic [79:0] held_bcd = 80'd0;
  logic        held_isaret = 1'b0;
  logic        held_gecerli = 1'b0;
  logic        held_tasma = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits by repeated division; sign/magnitude in the
  // signed build; error results are all-zero with the overflow flag copied.
  function automatic beklenen_t model(input logic [63:0] v, input logic gv, input logic tv);
    beklenen_t   e;
    logic [63:0] m;
    logic        neg;
    m   = v;
    neg = 1'b0;
`ifdef ISARETLI_SONUC_EN
    if (v[63]) begin
      m   = 64'd0 - v;
      neg = 1'b1;
    end
`endif
    e.bcd = 80'd0;
    for (int i = 0; i < 20; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 64'd10);
      m = m / 64'd10;
    end
    e.isaret  = neg;
    e.gecerli = 1'b1;
    e.tasma   = 1'b0;
    e.cyc     = 64;
    if (!gv || tv) begin
      e.bcd     = 80'd0;
      e.isaret  = 1'b0;
      e.gecerli = 1'b0;
      e.tasma   = tv;
      e.cyc     = 1;
    end
    return e;
  endfunction

  // Monitor: compare on tamam, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_tamam) begin
        check("hazir_after_tamam", {79'd0, bus.hazir}, 80'd1);
        check("tamam_one_cycle", {79'd0, bus.tamam}, 80'd0);
      end
      if (bus.tamam) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tamam: got tamam=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          beklenen_t e;
          e = sb.pop_front();
          check("bcd", bus.bcd, e.bcd);
          check("isaret", {79'd0, bus.isaret}, {79'd0, e.isaret});
          check("gecerli", {79'd0, bus.gecerli}, {79'd0, e.gecerli});
          check("tasma", {79'd0, bus.tasma}, {79'd0, e.tasma});
          check("latency", 80'(cyc), 80'(e.cyc));
          held_bcd     = e.bcd;
          held_isaret  = e.isaret;
          held_gecerli = e.gecerli;
          held_tasma   = e.tasma;
        end
      end else begin
        check("hold_bcd", bus.bcd, held_bcd);
        check("hold_flags", {77'd0, bus.isaret, bus.gecerli, bus.tasma},
              {77'd0, held_isaret, held_gecerli, held_tasma});
      end
      prev_tamam = bus.tamam;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for hazir, pulse basla for one edge, then queue the expectation.
  task automatic start(input logic [63:0] v, input logic gv, input logic tv);
    int        n;
    beklenen_t e;
    n = 0;
    while (!bus.hazir && n < 200) begin
      tick();
      n++;
    end
    if (!bus.hazir) begin
      tests++;
      fails++;
      $display("FAIL hazir_timeout: got hazir=0 expected 1 within 200 cycles");
    end
    bus.sonuc      = v;
    bus.gecerli_in = gv;
    bus.tasma_in   = tv;
    bus.basla      = 1'b1;
    tick();
    bus.basla = 1'b0;
    e = model(v, gv, tv);
    e.cyc = e.cyc + cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    logic [63:0] v;
    rst            = 1'b1;
    bus.sonuc      = 64'd0;
    bus.gecerli_in = 1'b0;
    bus.tasma_in   = 1'b0;
    bus.basla      = 1'b1;   // reset must win over basla
    tick();
    tick();
    check("rst_bcd", bus.bcd, 80'd0);
    check("rst_flags", {75'd0, bus.isaret, bus.hazir, bus.tamam, bus.gecerli, bus.tasma},
          {75'd0, 5'b01000});
    bus.basla = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_hazir", {79'd0, bus.hazir}, 80'd1);
    mon_en = 1'b1;

    // Directed corner values
    start(64'd12345, 1'b1, 1'b0);              drain();
    start(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0); drain();
    start(64'h8000_0000_0000_0000, 1'b1, 1'b0); drain();
    start(64'd0, 1'b1, 1'b0);                  drain();
    start(64'd999, 1'b1, 1'b1);                drain();
    start(64'd777, 1'b0, 1'b0);                drain();
    start(64'd555, 1'b0, 1'b1);                drain();

    // basla during a conversion is ignored and not queued
    start(64'd9876543210, 1'b1, 1'b0);
    repeat (10) tick();
    bus.sonuc = 64'd42;
    bus.basla = 1'b1;
    tick();
    bus.basla = 1'b0;
    drain();
    repeat (3) tick();

    // Reset 30 cycles into a conversion aborts it
    start(64'd31415926535, 1'b1, 1'b0);
    repeat (29) tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    held_bcd     = 80'd0;
    held_isaret  = 1'b0;
    held_gecerli = 1'b0;
    held_tasma   = 1'b0;
    check("abort_bcd", bus.bcd, 80'd0);
    check("abort_flags", {75'd0, bus.isaret, bus.hazir, bus.tamam, bus.gecerli, bus.tasma},
          {75'd0, 5'b01000});
    start(64'd27182818284, 1'b1, 1'b0);
    drain();

    // Randomised operands and flags
    for (int i = 0; i < 25; i++) begin
      v = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) v = v >> $urandom_range(1, 63);
      start(v, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) drain();
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
